// File: rtl/spraid_pkg.sv
// spraid_pkg: mode codes, FSM states and lane width shared by the RAID front end.
package spraid_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    MODE_RAID1  = 2'd0,
    MODE_RAID0  = 2'd1,
    MODE_PARITY = 2'd2
  } raid_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4
  } state_e;

endpackage

// File: rtl/spraid_parity.sv
// spraid_parity: combinational parity generation, check and single-lane rebuild.
// Only instantiated when SPRAID_PARITY_EN is defined.
module spraid_parity
  import spraid_pkg::*;
#(
  parameter int N_DRIVES = 4
) (
  input  logic [N_DRIVES*LANE_W-1:0] wr_data,
  input  logic [N_DRIVES*LANE_W-1:0] rd_data,
  input  logic [N_DRIVES-1:0]        rd_fail,
  output logic [LANE_W-1:0]          wr_parity,
  output logic [N_DRIVES*LANE_W-1:0] rd_fixed,
  output logic                       rd_mismatch
);

  localparam int LW = N_DRIVES * LANE_W;

  function automatic logic [LANE_W-1:0] xor_lanes(input logic [LW-1:0] d,
                                                  input logic [N_DRIVES-1:0] keep);
    logic [LANE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_DRIVES; i++) begin
      acc = acc ^ (d[i*LANE_W +: LANE_W] & {LANE_W{keep[i]}});
    end
    return acc;
  endfunction

  logic [LANE_W-1:0] rd_xor;

  // XOR of the surviving lanes equals the missing lane, or zero when all agree
  always_comb begin
    wr_parity   = xor_lanes(wr_data, {1'b0, {(N_DRIVES-1){1'b1}}});
    rd_xor      = xor_lanes(rd_data, ~rd_fail);
    rd_mismatch = |rd_xor;
    rd_fixed    = '0;
    for (int i = 0; i < N_DRIVES - 1; i++) begin
      if (rd_fail[i]) rd_fixed[i*LANE_W +: LANE_W] = rd_xor;
      else            rd_fixed[i*LANE_W +: LANE_W] = rd_data[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/spraid_array.sv
// spraid_array: RAID0/RAID1 (and parity when SPRAID_PARITY_EN is defined) sequencer
// between a Wishbone slave and N byte-wide SPI flash controllers.
module spraid_array
  import spraid_pkg::*;
#(
  parameter int N_DRIVES    = 4,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 raid_type,
  input  logic                       wb_stb,
  input  logic                       wb_we,
  input  logic [ADDR_W-1:0]          wb_adr,
  input  logic [N_DRIVES*LANE_W-1:0] wb_dat_i,
  output logic [N_DRIVES*LANE_W-1:0] wb_dat_o,
  output logic                       wb_ack,
  output logic                       err,
  output logic                       busy,
  input  logic [N_DRIVES-1:0]        drv_fail,
  output logic [N_DRIVES-1:0]        drv_rd,
  output logic [N_DRIVES-1:0]        drv_wr,
  output logic [ADDR_W-1:0]          drv_addr,
  output logic [N_DRIVES*LANE_W-1:0] drv_wdata,
  input  logic [N_DRIVES*LANE_W-1:0] drv_rdata,
  input  logic [N_DRIVES-1:0]        drv_busy
);

  localparam int          LW      = N_DRIVES * LANE_W;
  localparam logic [16:0] TMO     = 17'(TIMEOUT_CYC);
  localparam logic [16:0] CNT_MAX = 17'h1FFFF;

  state_e              state_q, state_d;
  logic [1:0]          raid_q, raid_d;
  logic                we_q, we_d;
  logic [N_DRIVES-1:0] en_q, en_d;
  logic [16:0]         cnt_q, cnt_d;
  logic [N_DRIVES-1:0] drv_rd_q, drv_rd_d, drv_wr_q, drv_wr_d;
  logic [ADDR_W-1:0]   drv_addr_q, drv_addr_d;
  logic [LW-1:0]       drv_wdata_q, drv_wdata_d, wb_dat_o_q, wb_dat_o_d;
  logic                wb_ack_q, wb_ack_d, err_q, err_d, busy_q, busy_d;

  logic                accept_ok, rd_err, wait_done, disagree;
  logic [LW-1:0]       wr_lanes, rd_data;
  logic [LANE_W-1:0]   sel_lane;

`ifdef SPRAID_PARITY_EN
  localparam logic [N_DRIVES-1:0] ONE_N = N_DRIVES'(1);
  logic [LANE_W-1:0] par_wr;
  logic [LW-1:0]     par_rd;
  logic              par_mismatch, multi_fail;

  assign multi_fail = |(drv_fail & (drv_fail - ONE_N));

  spraid_parity #(.N_DRIVES(N_DRIVES)) u_parity (
    .wr_data     (wb_dat_i),
    .rd_data     (drv_rdata),
    .rd_fail     (~en_q),
    .wr_parity   (par_wr),
    .rd_fixed    (par_rd),
    .rd_mismatch (par_mismatch)
  );
`endif

  // Request legality and per-drive write lanes, decided from live inputs at accept
  always_comb begin
    case (raid_type)
      MODE_RAID1: begin
        accept_ok = |(~drv_fail);
        wr_lanes  = {N_DRIVES{wb_dat_i[LANE_W-1:0]}};
      end
      MODE_RAID0: begin
        accept_ok = ~|drv_fail;
        wr_lanes  = wb_dat_i;
      end
`ifdef SPRAID_PARITY_EN
      MODE_PARITY: begin
        accept_ok = ~multi_fail;
        wr_lanes  = {par_wr, wb_dat_i[LW-LANE_W-1:0]};
      end
`endif
      default: begin
        accept_ok = 1'b0;
        wr_lanes  = '0;
      end
    endcase
  end

  // Read result and status, evaluated in the cycle WAIT exits
  always_comb begin
    sel_lane = '0;
    disagree = 1'b0;
    for (int i = N_DRIVES - 1; i >= 0; i--) begin
      if (en_q[i]) sel_lane = drv_rdata[i*LANE_W +: LANE_W];
      else         sel_lane = sel_lane;
    end
    for (int i = 0; i < N_DRIVES; i++) begin
      if (en_q[i] && (drv_rdata[i*LANE_W +: LANE_W] != sel_lane)) disagree = 1'b1;
      else                                                        disagree = disagree;
    end
    case (raid_q)
      MODE_RAID1: begin
        rd_data = {{(LW-LANE_W){1'b0}}, sel_lane};
        rd_err  = disagree;
      end
      MODE_RAID0: begin
        rd_data = drv_rdata;
        rd_err  = 1'b0;
      end
`ifdef SPRAID_PARITY_EN
      MODE_PARITY: begin
        rd_data = par_rd;
        rd_err  = (&en_q) & par_mismatch;
      end
`endif
      default: begin
        rd_data = '0;
        rd_err  = 1'b1;
      end
    endcase
  end

  assign wait_done = ~|(drv_busy & en_q);

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      raid_q      <= 2'd0;
      we_q        <= 1'b0;
      en_q        <= '0;
      cnt_q       <= 17'd0;
      drv_rd_q    <= '0;
      drv_wr_q    <= '0;
      drv_addr_q  <= '0;
      drv_wdata_q <= '0;
      wb_dat_o_q  <= '0;
      wb_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raid_q      <= raid_d;
      we_q        <= we_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
      drv_rd_q    <= drv_rd_d;
      drv_wr_q    <= drv_wr_d;
      drv_addr_q  <= drv_addr_d;
      drv_wdata_q <= drv_wdata_d;
      wb_dat_o_q  <= wb_dat_o_d;
      wb_ack_q    <= wb_ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (!wb_stb)        state_d = ST_IDLE;
        else if (accept_ok) state_d = ST_ISSUE;
        else                state_d = ST_ACK;
      end
      ST_ISSUE: state_d = ST_GUARD;
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_done || (cnt_q == TMO)) state_d = ST_ACK;
        else                             state_d = ST_WAIT;
      end
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; pulses and ack are loaded one cycle ahead
  always_comb begin
    raid_d      = raid_q;
    we_d        = we_q;
    en_d        = en_q;
    cnt_d       = cnt_q;
    drv_rd_d    = '0;
    drv_wr_d    = '0;
    drv_addr_d  = drv_addr_q;
    drv_wdata_d = drv_wdata_q;
    wb_dat_o_d  = wb_dat_o_q;
    wb_ack_d    = 1'b0;
    err_d       = err_q;
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (wb_stb) begin
          raid_d      = raid_type;
          we_d        = wb_we;
          en_d        = ~drv_fail;
          drv_addr_d  = wb_adr;
          drv_wdata_d = wr_lanes;
          if (accept_ok) begin
            err_d = 1'b0;
            if (wb_we) drv_wr_d = ~drv_fail;
            else       drv_rd_d = ~drv_fail;
          end else begin
            err_d      = 1'b1;
            wb_ack_d   = 1'b1;
            wb_dat_o_d = '0;
          end
        end else begin
          err_d = err_q;
        end
      end
      ST_GUARD: cnt_d = 17'd0;
      ST_WAIT: begin
        if (wait_done) begin
          wb_ack_d   = 1'b1;
          wb_dat_o_d = we_q ? '0 : rd_data;
          err_d      = we_q ? 1'b0 : rd_err;
        end else if (cnt_q == TMO) begin
          wb_ack_d   = 1'b1;
          wb_dat_o_d = '0;
          err_d      = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 17'd1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  assign drv_rd    = drv_rd_q;
  assign drv_wr    = drv_wr_q;
  assign drv_addr  = drv_addr_q;
  assign drv_wdata = drv_wdata_q;
  assign wb_dat_o  = wb_dat_o_q;
  assign wb_ack    = wb_ack_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spraid_array.sv
// tb_spraid_array: scoreboard bench with a behavioural four-drive flash model.
module tb_spraid_array;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int TMO = 300;
  localparam int LW  = 8 * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    raid_type;
  logic          wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [LW-1:0] wb_dat_i, wb_dat_o;
  logic          wb_ack, err, busy;
  logic [N-1:0]  drv_fail, drv_rd, drv_wr, drv_busy;
  logic [AW-1:0] drv_addr;
  logic [LW-1:0] drv_wdata, drv_rdata;

  typedef struct {
    logic [LW-1:0] dat;
    logic          chk_dat;
    logic          err;
    int            lat;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spraid_array #(.N_DRIVES(N), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .raid_type(raid_type), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .err(err), .busy(busy), .drv_fail(drv_fail), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_rdata(drv_rdata), .drv_busy(drv_busy)
  );

  // Drive model: byte memories, read latch, busy for busy_len cycles after a request
  logic [7:0] mem [N][256];
  logic [7:0] rd_lat [N];
  logic [7:0] corrupt [N];
  int         busy_cnt [N];
  int         busy_len = 1;
  int         cyc = 0;
  int         hold_until = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (cyc == 0) begin
        for (int a = 0; a < 256; a++) mem[i][a] <= 8'h00;
        rd_lat[i]   <= 8'h00;
        busy_cnt[i] <= 0;
      end else begin
        if (drv_wr[i]) mem[i][drv_addr[7:0]] <= drv_wdata[i*8 +: 8];
        if (drv_rd[i]) rd_lat[i] <= mem[i][drv_addr[7:0]];
        if (drv_rd[i] || drv_wr[i]) busy_cnt[i] <= busy_len;
        else if (busy_cnt[i] > 0)   busy_cnt[i] <= busy_cnt[i] - 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      drv_busy[i]         = (busy_cnt[i] != 0);
      drv_rdata[i*8 +: 8] = rd_lat[i] ^ corrupt[i];
    end
    drv_busy[0] = drv_busy[0] | (cyc < hold_until);
  end

  // One Wishbone transaction; lat counts cycles from accept to ack (0 = never acked)
  task automatic do_txn(input logic [1:0] m, input logic we, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, input logic [N-1:0] f,
                        output logic [LW-1:0] od, output logic oe, output int lat,
                        output logic [N-1:0] ord, output logic [N-1:0] owr,
                        output logic [AW-1:0] oaddr, output logic [LW-1:0] owd);
    @(negedge clk);
    raid_type = m; wb_we = we; wb_adr = a; wb_dat_i = d; drv_fail = f; wb_stb = 1'b1;
    od = '0; oe = 1'b0; lat = 0; ord = '0; owr = '0; oaddr = '0; owd = '0;
    for (int c = 1; c <= TMO + 50; c++) begin
      @(negedge clk);
      ord = ord | drv_rd;
      owr = owr | drv_wr;
      if ((drv_rd | drv_wr) != '0) begin
        oaddr = drv_addr;
        owd   = drv_wdata;
      end
      if (wb_ack) begin
        lat = c;
        od  = wb_dat_o;
        oe  = err;
        break;
      end
    end
    wb_stb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; raid_type = 2'd0; wb_adr = '0;
    wb_dat_i = '0; drv_fail = '0;
    for (int i = 0; i < N; i++) corrupt[i] = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_ack, busy, err, drv_rd, drv_wr} !== '0) begin
      errors++; $display("FAIL reset_ctl: got %b want 0", {wb_ack, busy, err, drv_rd, drv_wr});
    end
    checks++;
    if ({wb_dat_o, drv_addr, drv_wdata} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {wb_dat_o, drv_addr, drv_wdata});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_ack, busy, err, drv_rd, drv_wr} !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %b want 0", {wb_ack, busy, err, drv_rd, drv_wr});
    end
  endtask

  task automatic test_raid0();
    logic [LW-1:0] od, owd; logic oe; int lat; logic [N-1:0] ord, owr; logic [AW-1:0] oa;
    exp_t e;
    exp_q.push_back('{dat: '0, chk_dat: 1'b0, err: 1'b0, lat: 4});
    do_txn(2'd1, 1'b1, 16'h0010, 32'hDDCCBBAA, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL r0_wr_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (oe !== e.err) begin errors++; $display("FAIL r0_wr_err: got %b want %b", oe, e.err); end
    checks++; if ({owr, ord} !== 8'hF0) begin errors++; $display("FAIL r0_wr_pulse: got %b want 11110000", {owr, ord}); end
    checks++; if ({oa, owd} !== {16'h0010, 32'hDDCCBBAA}) begin errors++; $display("FAIL r0_wr_bus: got %h want 0010ddccbbaa", {oa, owd}); end
    checks++;
    if ({mem[3][16], mem[2][16], mem[1][16], mem[0][16]} !== 32'hDDCCBBAA) begin
      errors++; $display("FAIL r0_mem: got %h want ddccbbaa", {mem[3][16], mem[2][16], mem[1][16], mem[0][16]});
    end
    exp_q.push_back('{dat: 32'hDDCCBBAA, chk_dat: 1'b1, err: 1'b0, lat: 4});
    do_txn(2'd1, 1'b0, 16'h0010, 32'h0, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL r0_rd_lat: got %0d want %0d", lat, e.lat); end
    checks++; if ({od, oe} !== {e.dat, e.err}) begin errors++; $display("FAIL r0_rd: got %h/%b want %h/%b", od, oe, e.dat, e.err); end
    checks++; if ({owr, ord} !== 8'h0F) begin errors++; $display("FAIL r0_rd_pulse: got %b want 00001111", {owr, ord}); end
    // A failed drive in RAID0 refuses the request outright
    exp_q.push_back('{dat: '0, chk_dat: 1'b1, err: 1'b1, lat: 0});
    do_txn(2'd1, 1'b0, 16'h0010, 32'h0, 4'b0100, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if (lat == 0) begin errors++; $display("FAIL r0_fail_ack: got no ack want ack"); end
    checks++; if ({od, oe} !== {e.dat, e.err}) begin errors++; $display("FAIL r0_fail: got %h/%b want %h/%b", od, oe, e.dat, e.err); end
    checks++; if ({owr, ord} !== 8'h00) begin errors++; $display("FAIL r0_fail_pulse: got %b want 0", {owr, ord}); end
  endtask

  task automatic test_raid1();
    logic [LW-1:0] od, owd; logic oe; int lat; logic [N-1:0] ord, owr; logic [AW-1:0] oa;
    exp_t e;
    exp_q.push_back('{dat: '0, chk_dat: 1'b0, err: 1'b0, lat: 4});
    do_txn(2'd0, 1'b1, 16'h0030, 32'h1122335A, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, oe} !== {e.lat, e.err}) begin errors++; $display("FAIL r1_wr: got %0d/%b want %0d/%b", lat, oe, e.lat, e.err); end
    checks++; if ({owr, owd} !== {4'b1111, 32'h5A5A5A5A}) begin errors++; $display("FAIL r1_wr_bus: got %b/%h want 1111/5a5a5a5a", owr, owd); end
    // Drive 2 returns a flipped bit
    corrupt[2] = 8'h01;
    exp_q.push_back('{dat: 32'h0000005A, chk_dat: 1'b1, err: 1'b1, lat: 4});
    do_txn(2'd0, 1'b0, 16'h0030, 32'h0, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe} !== {e.lat, e.dat, e.err}) begin errors++; $display("FAIL r1_disagree: got %0d/%h/%b want %0d/%h/%b", lat, od, oe, e.lat, e.dat, e.err); end
    corrupt[2] = 8'h00;
    // Drive 0 is garbage but excluded, so drive 1 supplies the data
    corrupt[0] = 8'hFF;
    exp_q.push_back('{dat: 32'h0000005A, chk_dat: 1'b1, err: 1'b0, lat: 4});
    do_txn(2'd0, 1'b0, 16'h0030, 32'h0, 4'b0001, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe} !== {e.lat, e.dat, e.err}) begin errors++; $display("FAIL r1_masked: got %0d/%h/%b want %0d/%h/%b", lat, od, oe, e.lat, e.dat, e.err); end
    checks++; if (ord !== 4'b1110) begin errors++; $display("FAIL r1_masked_rd: got %b want 1110", ord); end
    corrupt[0] = 8'h00;
    exp_q.push_back('{dat: '0, chk_dat: 1'b0, err: 1'b1, lat: 0});
    do_txn(2'd0, 1'b0, 16'h0030, 32'h0, 4'b1111, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if (lat == 0 || oe !== e.err || ord !== 4'b0000) begin errors++; $display("FAIL r1_allfail: got lat=%0d err=%b rd=%b want ack err=1 rd=0000", lat, oe, ord); end
  endtask

  task automatic test_parity();
    logic [LW-1:0] od, owd; logic oe; int lat; logic [N-1:0] ord, owr; logic [AW-1:0] oa;
    exp_t e;
`ifdef SPRAID_PARITY_EN
    exp_q.push_back('{dat: '0, chk_dat: 1'b0, err: 1'b0, lat: 4});
    do_txn(2'd2, 1'b1, 16'h0020, 32'h00332211, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, oe, owr, owd} !== {e.lat, e.err, 4'b1111, 32'h00332211}) begin errors++; $display("FAIL par_wr0: got %0d/%b/%b/%h want 4/0/1111/00332211", lat, oe, owr, owd); end
    exp_q.push_back('{dat: '0, chk_dat: 1'b0, err: 1'b0, lat: 4});
    do_txn(2'd2, 1'b1, 16'h0021, 32'hEE0F0501, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, oe, owd} !== {e.lat, e.err, 32'h0B0F0501}) begin errors++; $display("FAIL par_wr1: got %0d/%b/%h want 4/0/0b0f0501", lat, oe, owd); end
    exp_q.push_back('{dat: 32'h00332211, chk_dat: 1'b1, err: 1'b0, lat: 4});
    do_txn(2'd2, 1'b0, 16'h0020, 32'h0, 4'b0010, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe, ord} !== {e.lat, e.dat, e.err, 4'b1101}) begin errors++; $display("FAIL par_rebuild: got %0d/%h/%b/%b want %0d/%h/%b/1101", lat, od, oe, ord, e.lat, e.dat, e.err); end
    corrupt[1] = 8'h10;
    exp_q.push_back('{dat: 32'h000F1501, chk_dat: 1'b1, err: 1'b1, lat: 4});
    do_txn(2'd2, 1'b0, 16'h0021, 32'h0, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe} !== {e.lat, e.dat, e.err}) begin errors++; $display("FAIL par_mismatch: got %0d/%h/%b want %0d/%h/%b", lat, od, oe, e.lat, e.dat, e.err); end
    corrupt[1] = 8'h00;
    exp_q.push_back('{dat: '0, chk_dat: 1'b0, err: 1'b1, lat: 0});
    do_txn(2'd2, 1'b0, 16'h0021, 32'h0, 4'b0011, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if (lat == 0 || oe !== e.err) begin errors++; $display("FAIL par_twofail: got lat=%0d err=%b want ack err=1", lat, oe); end
`else
    exp_q.push_back('{dat: '0, chk_dat: 1'b1, err: 1'b1, lat: 1});
    do_txn(2'd2, 1'b1, 16'h0020, 32'h00332211, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe, ord, owr} !== {e.lat, e.dat, e.err, 8'h00}) begin errors++; $display("FAIL par_disabled: got %0d/%h/%b/%b/%b want 1/0/1/0/0", lat, od, oe, ord, owr); end
`endif
    exp_q.push_back('{dat: '0, chk_dat: 1'b1, err: 1'b1, lat: 1});
    do_txn(2'd3, 1'b0, 16'h0020, 32'h0, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe, ord, owr} !== {e.lat, e.dat, e.err, 8'h00}) begin errors++; $display("FAIL mode3_illegal: got %0d/%h/%b/%b/%b want 1/0/1/0/0", lat, od, oe, ord, owr); end
  endtask

  task automatic test_timeout();
    logic [LW-1:0] od, owd; logic oe; int lat; logic [N-1:0] ord, owr; logic [AW-1:0] oa;
    exp_t e;
    hold_until = cyc + TMO + 8;
    exp_q.push_back('{dat: '0, chk_dat: 1'b1, err: 1'b1, lat: TMO + 4});
    do_txn(2'd1, 1'b0, 16'h0010, 32'h0, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe} !== {e.lat, e.dat, e.err}) begin errors++; $display("FAIL timeout: got %0d/%h/%b want %0d/%h/%b", lat, od, oe, e.lat, e.dat, e.err); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] od, owd; logic oe; int lat; logic [N-1:0] ord, owr; logic [AW-1:0] oa;
    exp_t e;
    busy_len = 20;
    @(negedge clk);
    raid_type = 2'd1; wb_we = 1'b0; wb_adr = 16'h0010; drv_fail = 4'b0000; wb_stb = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b1; wb_stb = 1'b0;
    #1;
    checks++; if ({busy, wb_ack, err, drv_rd, drv_wr, drv_addr, drv_wdata} !== '0) begin errors++; $display("FAIL mid_reset: got %h want 0", {busy, wb_ack, err, drv_rd, drv_wr, drv_addr, drv_wdata}); end
    @(negedge clk);
    reset = 1'b0;
    busy_len = 1;
    repeat (25) @(negedge clk);
    exp_q.push_back('{dat: 32'hDDCCBBAA, chk_dat: 1'b1, err: 1'b0, lat: 4});
    do_txn(2'd1, 1'b0, 16'h0010, 32'h0, 4'b0000, od, oe, lat, ord, owr, oa, owd);
    e = exp_q.pop_front();
    checks++; if ({lat, od, oe} !== {e.lat, e.dat, e.err}) begin errors++; $display("FAIL post_reset_rd: got %0d/%h/%b want %0d/%h/%b", lat, od, oe, e.lat, e.dat, e.err); end
  endtask

  initial begin
    test_reset();
    test_raid0();
    test_raid1();
    test_parity();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spraid_array.md
# spraid_array

Parametrised RAID front end that sits between the Wishbone slave and an array of `N_DRIVES` byte-wide SPI flash controllers. Each host transaction is sequenced across all drives with a shared address and one byte per drive. Supported modes are byte-lane striping (RAID0), mirroring (RAID1) and, when configured, dedicated-parity striping with single-drive reconstruction. It replaces the fixed four-drive controller with per-drive failure masking, a timeout, and a proper request/ack handshake.

## Interface
- `N_DRIVES`, 4: drive count, 2..8.
- `ADDR_W`, 16: drive byte-address width.
- `TIMEOUT_CYC`, 65535: maximum wait cycles for the drives to go idle.
- `clk`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `raid_type`  in  2  mode: 0 = RAID1, 1 = RAID0, 2 = parity; sampled at accept.
- `wb_stb`  in  1  request strobe; held until `wb_ack`.
- `wb_we`  in  1  1 = write.
- `wb_adr`  in  ADDR_W  drive address.
- `wb_dat_i`  in  8*N_DRIVES  write data; byte i maps to lane i.
- `wb_dat_o`  out  8*N_DRIVES  read data, valid with `wb_ack`.
- `wb_ack`  out  1  one-cycle completion.
- `err`  out  1  status of the last transaction, valid from `wb_ack` until the next accept.
- `busy`  out  1  high in every state other than IDLE.
- `drv_fail`  in  N_DRIVES  drives to exclude; sampled at accept.
- `drv_rd`, `drv_wr`  out  N_DRIVES  one-cycle request pulses, per drive.
- `drv_addr`  out  ADDR_W  shared drive address.
- `drv_wdata`  out  8*N_DRIVES  per-drive write bytes.
- `drv_rdata`  in  8*N_DRIVES  per-drive read bytes.
- `drv_busy`  in  N_DRIVES  per-drive busy.

## Operation
- FSM states: IDLE → ISSUE → GUARD → WAIT → ACK → IDLE.
- **IDLE, `wb_stb`=1:** latch request fields, `raid_type` and `drv_fail`.
  - Enabled mask = ~`drv_fail`.
  - Illegal `raid_type`: go directly to ACK with `err`=1.
- **ISSUE:** pulse `drv_rd` or `drv_wr` on enabled drives; drive `drv_addr` and `drv_wdata`.
- **GUARD:** one cycle; `drv_busy` is ignored.
- **WAIT:** leave when every enabled drive has `drv_busy`=0.
  - If the counter reaches `TIMEOUT_CYC`, go to ACK with `err`=1.
- **ACK:** assert `wb_ack` for one cycle and capture `wb_dat_o`; return to IDLE.
- **RAID0:** lane i ↔ drive i.
  - Any failed drive ⇒ request not issued, `err`=1, read data 0.
- **RAID1:**
  - Write: `wb_dat_i[7:0]` goes to all enabled drives.
  - Read: data comes from the lowest-index enabled drive, zero-extended.
  - `err`=1 if any enabled drives disagree, or if all drives are failed.
- **Parity:**
  - Lanes 0..N-2 are data; drive N-1 stores the XOR of lanes 0..N-2.
  - Read with 0 failed drives: `err`=1 on XOR mismatch.
  - Read with 1 failed drive: its lane is reconstructed by XOR and `err`=0.
  - ≥2 failed drives ⇒ `err`=1.
  - The top lane of `wb_dat_o` is 0.
- Mid-operation `reset` aborts immediately and all outputs return to reset values.
- `wb_stb` still high in the cycle after ACK starts a new transaction; the master must drop it on `wb_ack`.

## Timing
- Reset values: all outputs 0.
- Accept at cycle T:
  - `drv_rd`/`drv_wr` pulse at T+1.
  - GUARD at T+2.
  - WAIT from T+3.
  - If WAIT exits at cycle W, `wb_ack` is at W+1.
- Minimum latency, with drives idle at T+3: `wb_ack` at T+4.
- Illegal mode: `wb_ack` at T+1.
- The timeout counter is 17 bits; it is cleared on entering WAIT and saturates.

## Configuration
- `SPRAID_PARITY_EN` defined: parity mode is compiled in, along with `spraid_parity`.
- Undefined: `raid_type`=2 is illegal, giving `err`=1 and no drive access.

## Structure
- `spraid_pkg` holds:
  - the mode codes RAID1=0, RAID0=1, PARITY=2;
  - the FSM state enum;
  - the byte-lane width constant 8.
- Sub-module `spraid_parity`, combinational:
  - XOR-reduces the data lanes;
  - compares the result against the parity lane;
  - reconstructs a single masked lane.

## Test plan
- RAID0 write, N=4, addr 0x0010, data 0xDDCCBBAA → drive0..3 get 0xAA/0xBB/0xCC/0xDD at 0x0010; readback 0xDDCCBBAA, `err`=0.
- RAID1 write 0x5A, then read; drive2 returns 0x5B → `wb_dat_o`=0x5A, `err`=1.
- RAID1 read with `drv_fail`=0b0001 → data from drive1, `drv_rd`=0b1110.
- Parity write 0x00332211 → drive3 gets 0x00; read with `drv_fail`=0b0010 → 0x00332211, `err`=0.
- Drive0 holds busy for `TIMEOUT_CYC`+5 cycles → `wb_ack` with `err`=1, FSM back in IDLE.
- `reset` during WAIT → `busy`/`wb_ack`/`drv_*` = 0 next cycle; a fresh request then completes normally.
